// File: rtl/fc_layer_engine_if.sv
// fc_layer_engine_if: launch handshake, SRAM read ports and output write port of the FC engine.
// The engine connects through "master"; the sequencer/memory side connects through "slave".
interface fc_layer_engine_if #(
   parameter int DATA_WIDTH  = 16,
   parameter int LANES       = 4,
   parameter int IN_NEURONS  = 120,
   parameter int OUT_NEURONS = 84
);
   localparam int CHUNKS = (IN_NEURONS + LANES - 1) / LANES;
   localparam int IN_AW  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam int W_AW   = (OUT_NEURONS * CHUNKS > 1) ? $clog2(OUT_NEURONS * CHUNKS) : 1;
   localparam int OUT_AW = (OUT_NEURONS > 1) ? $clog2(OUT_NEURONS) : 1;

   logic                        start;
   logic                        busy;
   logic                        done;
   logic [IN_AW-1:0]            in_rd_addr;
   logic [LANES*DATA_WIDTH-1:0] in_rd_data;
   logic [W_AW-1:0]             w_rd_addr;
   logic [LANES*DATA_WIDTH-1:0] w_rd_data;
   logic [OUT_AW-1:0]           bias_rd_addr;
   logic [DATA_WIDTH-1:0]       bias_rd_data;
   logic                        out_wr_en;
   logic [OUT_AW-1:0]           out_wr_addr;
   logic [DATA_WIDTH-1:0]       out_wr_data;
   logic                        sat_flag;

   modport master (
      input  start, in_rd_data, w_rd_data, bias_rd_data,
      output busy, done, in_rd_addr, w_rd_addr, bias_rd_addr,
             out_wr_en, out_wr_addr, out_wr_data, sat_flag
   );

   modport slave (
      output start, in_rd_data, w_rd_data, bias_rd_data,
      input  busy, done, in_rd_addr, w_rd_addr, bias_rd_addr,
             out_wr_en, out_wr_addr, out_wr_data, sat_flag
   );
endinterface

// File: rtl/fc_layer_engine.sv
// fc_layer_engine: LANES-wide MAC engine for a fully-connected layer with fused bias, rounding,
// saturation and optional ReLU (define FC_RELU_EN to clamp negative outputs to zero).
module fc_layer_engine #(
   parameter int DATA_WIDTH  = 16,
   parameter int FRAC_BITS   = 8,
   parameter int IN_NEURONS  = 120,
   parameter int OUT_NEURONS = 84,
   parameter int LANES       = 4,
   parameter int ACC_WIDTH   = 40
) (
   input logic               clk,
   input logic               rst,
   fc_layer_engine_if.master bus
);
   localparam int DW     = DATA_WIDTH;
   localparam int CHUNKS = (IN_NEURONS + LANES - 1) / LANES;
   localparam int IN_AW  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam int W_AW   = (OUT_NEURONS * CHUNKS > 1) ? $clog2(OUT_NEURONS * CHUNKS) : 1;
   localparam int OUT_AW = (OUT_NEURONS > 1) ? $clog2(OUT_NEURONS) : 1;
   localparam int PW     = 2 * DW;
   localparam int SW     = PW + $clog2(LANES) + 1;
   localparam int RW     = ACC_WIDTH + 2;
   localparam logic signed [RW-1:0] SAT_MAX = RW'((64'sd1 <<< (DW - 1)) - 64'sd1);
   localparam logic signed [RW-1:0] SAT_MIN = RW'(-(64'sd1 <<< (DW - 1)));
   localparam logic signed [RW-1:0] HALF    = RW'(64'sd1 <<< (FRAC_BITS - 1));

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t state, state_next;
   logic issue, accept, last_k, last_j;
   logic [IN_AW-1:0]  k_cnt;
   logic [OUT_AW-1:0] j_cnt;
   logic [W_AW-1:0]   w_cnt;
   logic [LANES-1:0]  lane_mask, mask1;
   logic v1, v2, v3, v4, first1, first2, first3, last1, last2, last3, last4;
   logic [OUT_AW-1:0] j1, j2, j3, j4;
   logic signed [DW-1:0] bias2, bias3, bias4;
   logic signed [PW-1:0] prod_c [LANES];
   logic signed [PW-1:0] prod2 [LANES];
   logic signed [SW-1:0] lane_sum, sum3;
   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [RW-1:0] biased, shifted;
   logic [DW-1:0] sat_val, result;
   logic clip;
   logic wr_en_q, sat_q;
   logic [OUT_AW-1:0] wr_addr_q;
   logic [DW-1:0] wr_data_q;

   assign last_k = (k_cnt == IN_AW'(CHUNKS - 1));
   assign last_j = (j_cnt == OUT_AW'(OUT_NEURONS - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // DRAIN lasts until every pipeline tag has retired, so done follows the final write.
   always_comb begin
      state_next = state;
      issue      = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE:    if (bus.start) begin
                     accept     = 1'b1;
                     state_next = RUN;
                  end
         RUN:     begin
                     issue = 1'b1;
                     if (last_k && last_j) state_next = DRAIN;
                  end
         DRAIN:   if (!(v1 || v2 || v3 || v4)) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign bus.busy = (state != IDLE);
   assign bus.done = (state == DONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         k_cnt <= '0;
         j_cnt <= '0;
         w_cnt <= '0;
      end else if (accept) begin
         k_cnt <= '0;
         j_cnt <= '0;
         w_cnt <= '0;
      end else if (issue) begin
         w_cnt <= (last_k && last_j) ? '0 : w_cnt + 1'b1;
         if (last_k) begin
            k_cnt <= '0;
            j_cnt <= last_j ? '0 : j_cnt + 1'b1;
         end else begin
            k_cnt <= k_cnt + 1'b1;
         end
      end
   end

   assign bus.in_rd_addr   = k_cnt;
   assign bus.w_rd_addr    = w_cnt;
   assign bus.bias_rd_addr = j_cnt;

   // Lanes past the end of the input vector are zeroed whatever the memory holds there.
   always_comb begin
      lane_mask = '0;
      for (int l = 0; l < LANES; l++)
         lane_mask[l] = (int'(k_cnt) * LANES + l) < IN_NEURONS;
   end

   always_comb begin
      for (int l = 0; l < LANES; l++)
         prod_c[l] = PW'($signed(bus.in_rd_data[l*DW +: DW])) * PW'($signed(bus.w_rd_data[l*DW +: DW]));
   end

   always_comb begin
      lane_sum = '0;
      for (int l = 0; l < LANES; l++)
         lane_sum = lane_sum + SW'(prod2[l]);
   end

   // Tags ride alongside the data; bias is captured on the first beat and follows the neuron.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         {v1, first1, last1, v2, first2, last2, v3, first3, last3, v4, last4} <= '0;
         {j1, j2, j3, j4} <= '0;
         mask1 <= '0;
         {bias2, bias3, bias4} <= '0;
         for (int l = 0; l < LANES; l++) prod2[l] <= '0;
         sum3 <= '0;
         acc  <= '0;
      end else begin
         v1     <= issue;
         first1 <= (k_cnt == '0);
         last1  <= last_k;
         j1     <= j_cnt;
         mask1  <= lane_mask;
         v2     <= v1;
         first2 <= first1;
         last2  <= last1;
         j2     <= j1;
         if (first1) bias2 <= bus.bias_rd_data;
         for (int l = 0; l < LANES; l++) prod2[l] <= mask1[l] ? prod_c[l] : '0;
         v3     <= v2;
         first3 <= first2;
         last3  <= last2;
         j3     <= j2;
         bias3  <= bias2;
         sum3   <= lane_sum;
         v4     <= v3;
         last4  <= last3;
         j4     <= j3;
         bias4  <= bias3;
         if (v3) acc <= first3 ? ACC_WIDTH'(sum3) : acc + ACC_WIDTH'(sum3);
      end
   end

   always_comb begin
      biased  = RW'(acc) + (RW'(bias4) <<< FRAC_BITS) + HALF;
      shifted = biased >>> FRAC_BITS;
      clip    = 1'b0;
      sat_val = shifted[DW-1:0];
      if (shifted > SAT_MAX) begin
         sat_val = SAT_MAX[DW-1:0];
         clip    = 1'b1;
      end else if (shifted < SAT_MIN) begin
         sat_val = SAT_MIN[DW-1:0];
         clip    = 1'b1;
      end
`ifdef FC_RELU_EN
      result = sat_val[DW-1] ? '0 : sat_val;
`else
      result = sat_val;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         sat_q     <= 1'b0;
      end else begin
         wr_en_q <= v4 && last4;
         if (v4 && last4) begin
            wr_addr_q <= j4;
            wr_data_q <= result;
         end
         if (accept) sat_q <= 1'b0;
         else if (v4 && last4 && clip) sat_q <= 1'b1;
      end
   end

   assign bus.out_wr_en   = wr_en_q;
   assign bus.out_wr_addr = wr_addr_q;
   assign bus.out_wr_data = wr_data_q;
   assign bus.sat_flag    = sat_q;
endmodule

// File: tb/tb_fc_layer_engine.sv
// tb_fc_layer_engine: checks fc_layer_engine against an arithmetic dot-product model; a default
// 120x84 instance and a 10x4 instance whose last chunk has padding lanes.
module tb_fc_layer_engine;
   localparam int DW      = 16;
   localparam int LANES   = 4;
   localparam int BIG_IN  = 120;
   localparam int BIG_OUT = 84;
   localparam int BIG_CH  = 30;
   localparam int SML_IN  = 10;
   localparam int SML_OUT = 4;
   localparam int SML_CH  = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fc_layer_engine_if #(.DATA_WIDTH(DW), .LANES(LANES), .IN_NEURONS(BIG_IN), .OUT_NEURONS(BIG_OUT)) big_if ();
   fc_layer_engine_if #(.DATA_WIDTH(DW), .LANES(LANES), .IN_NEURONS(SML_IN), .OUT_NEURONS(SML_OUT)) sml_if ();

   fc_layer_engine #(.DATA_WIDTH(DW), .FRAC_BITS(8), .IN_NEURONS(BIG_IN), .OUT_NEURONS(BIG_OUT),
                     .LANES(LANES), .ACC_WIDTH(40))
      dut_big (.clk(clk), .rst(rst), .bus(big_if.master));

   fc_layer_engine #(.DATA_WIDTH(DW), .FRAC_BITS(8), .IN_NEURONS(SML_IN), .OUT_NEURONS(SML_OUT),
                     .LANES(LANES), .ACC_WIDTH(40))
      dut_sml (.clk(clk), .rst(rst), .bus(sml_if.master));

   bit signed [DW-1:0] act [BIG_IN];
   bit signed [DW-1:0] wt [BIG_OUT][BIG_IN];
   bit signed [DW-1:0] bias [BIG_OUT];
   bit [DW-1:0] pad_val;
   bit [DW-1:0] exp_data [BIG_OUT];
   bit exp_sat;
   bit [DW-1:0] round_w [4] = '{16'h0080, 16'hFF80, 16'hFF7F, 16'h0040};
   int cyc = 0;
   int start_cyc = 0;
   int errors = 0;
   int checks = 0;
   int wr_addr_q[$];
   int wr_cyc_q[$];
   logic [DW-1:0] wr_data_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [LANES*DW-1:0] pack_word(input int j, input int k, input int n_in, input bit is_w);
      logic [LANES*DW-1:0] word;
      word = '0;
      for (int l = 0; l < LANES; l++) begin
         int i;
         i = k * LANES + l;
         if (i < n_in && j < BIG_OUT) word[l*DW +: DW] = is_w ? wt[j][i] : act[i];
         else word[l*DW +: DW] = pad_val;
      end
      return word;
   endfunction

   function automatic logic [DW-1:0] get_bias(input int j);
      return (j < BIG_OUT) ? bias[j] : '0;
   endfunction

   // Synchronous-read SRAM models with one cycle of latency, backed by the stimulus arrays.
   always @(posedge clk) begin
      big_if.in_rd_data   <= pack_word(0, int'(big_if.in_rd_addr), BIG_IN, 1'b0);
      big_if.w_rd_data    <= pack_word(int'(big_if.w_rd_addr) / BIG_CH, int'(big_if.w_rd_addr) % BIG_CH, BIG_IN, 1'b1);
      big_if.bias_rd_data <= get_bias(int'(big_if.bias_rd_addr));
      sml_if.in_rd_data   <= pack_word(0, int'(sml_if.in_rd_addr), SML_IN, 1'b0);
      sml_if.w_rd_data    <= pack_word(int'(sml_if.w_rd_addr) / SML_CH, int'(sml_if.w_rd_addr) % SML_CH, SML_IN, 1'b1);
      sml_if.bias_rd_data <= get_bias(int'(sml_if.bias_rd_addr));
   end

   always @(negedge clk) begin
      if (big_if.out_wr_en) begin
         wr_addr_q.push_back(int'(big_if.out_wr_addr));
         wr_data_q.push_back(big_if.out_wr_data);
         wr_cyc_q.push_back(cyc - start_cyc);
      end
      if (sml_if.out_wr_en) begin
         wr_addr_q.push_back(int'(sml_if.out_wr_addr));
         wr_data_q.push_back(sml_if.out_wr_data);
         wr_cyc_q.push_back(cyc - start_cyc);
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expected);
      checks++;
      if (got !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, expected);
      end
   endtask

   function automatic logic get_done(input int sel);
      return (sel == 0) ? big_if.done : sml_if.done;
   endfunction

   function automatic logic get_busy(input int sel);
      return (sel == 0) ? big_if.busy : sml_if.busy;
   endfunction

   function automatic logic get_sat(input int sel);
      return (sel == 0) ? big_if.sat_flag : sml_if.sat_flag;
   endfunction

   task automatic drive_start(input int sel, input logic v);
      if (sel == 0) big_if.start = v;
      else sml_if.start = v;
   endtask

   // Reference: exact dot product over the real inputs, then bias, round half up, clip, ReLU.
   task automatic compute_model(input int n_in, input int n_out);
      longint s, r;
      exp_sat = 1'b0;
      for (int j = 0; j < n_out; j++) begin
         s = 0;
         for (int i = 0; i < n_in; i++) s += longint'(act[i]) * longint'(wt[j][i]);
         s = s + longint'(bias[j]) * 256 + 128;
         r = s >>> 8;
         if (r > 32767) begin r = 32767; exp_sat = 1'b1; end
         if (r < -32768) begin r = -32768; exp_sat = 1'b1; end
`ifdef FC_RELU_EN
         if (r < 0) r = 0;
`endif
         exp_data[j] = r[DW-1:0];
      end
   endtask

   task automatic applyStimulus(input int mode);
      pad_val = (mode >= 4) ? DW'($urandom) : 16'h7FFF;
      for (int i = 0; i < BIG_IN; i++) begin
         case (mode)
            0, 1: act[i] = 16'sh0100;
            2:    act[i] = 16'sh7FFF;
            3:    act[i] = DW'(int'($urandom_range(0, 511)) - 256);
            4:    act[i] = DW'($urandom);
            default: act[i] = (i == 0) ? 16'sh0001 : 16'sh0000;
         endcase
      end
      for (int j = 0; j < BIG_OUT; j++) begin
         case (mode)
            1:       bias[j] = 16'sh0180;
            3:       bias[j] = DW'(int'($urandom_range(0, 16383)) - 8192);
            4:       bias[j] = DW'($urandom);
            default: bias[j] = 16'sh0000;
         endcase
         for (int i = 0; i < BIG_IN; i++) begin
            case (mode)
               0:       wt[j][i] = 16'sh0100;
               1:       wt[j][i] = 16'shFF00;
               2:       wt[j][i] = 16'sh7FFF;
               3:       wt[j][i] = DW'(int'($urandom_range(0, 511)) - 256);
               4:       wt[j][i] = DW'($urandom);
               default: wt[j][i] = (i == 0) ? round_w[j % 4] : 16'sh0000;
            endcase
         end
      end
   endtask

   task automatic check_word(input string tag, input int idx, input logic [DW-1:0] expected);
      logic [63:0] got;
      got = (wr_data_q.size() > idx) ? 64'(wr_data_q[idx]) : 64'hFFFF_FFFF_FFFF_FFFF;
      checkOutput(tag, got, 64'(expected));
   endtask

   task automatic run_engine(input int sel, input int n_in, input int n_out, input int chunks, input bit stray);
      int done_rel;
      int nw;
      compute_model(n_in, n_out);
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_cyc_q.delete();
      @(negedge clk);
      drive_start(sel, 1'b1);
      start_cyc = cyc;
      @(negedge clk);
      drive_start(sel, 1'b0);
      checkOutput("busy_after_start", 64'(get_busy(sel)), 64'd1);
      done_rel = -1;
      for (int t = 0; t < n_out * chunks + 40 && done_rel < 0; t++) begin
         if (get_done(sel)) done_rel = cyc - start_cyc;
         else begin
            @(negedge clk);
            drive_start(sel, stray && (cyc - start_cyc) == 500);
         end
      end
      checkOutput("done_cycle", 64'(done_rel), 64'(n_out * chunks + 6));
      @(negedge clk);
      checkOutput("busy_after_done", 64'(get_busy(sel)), 64'd0);
      checkOutput("done_one_cycle", 64'(get_done(sel)), 64'd0);
      checkOutput("write_count", 64'(wr_addr_q.size()), 64'(n_out));
      nw = (wr_addr_q.size() < n_out) ? wr_addr_q.size() : n_out;
      for (int j = 0; j < nw; j++) begin
         checkOutput($sformatf("wr_addr[%0d]", j), 64'(wr_addr_q[j]), 64'(j));
         checkOutput($sformatf("wr_data[%0d]", j), 64'(wr_data_q[j]), 64'(exp_data[j]));
         checkOutput($sformatf("wr_cycle[%0d]", j), 64'(wr_cyc_q[j]), 64'((j + 1) * chunks + 5));
      end
      checkOutput("sat_flag", 64'(get_sat(sel)), 64'(exp_sat));
   endtask

   initial begin
      int n_before;
      big_if.start = 1'b0;
      sml_if.start = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_busy", 64'(big_if.busy), 64'd0);
      checkOutput("reset_done", 64'(big_if.done), 64'd0);
      checkOutput("reset_wr_en", 64'(big_if.out_wr_en), 64'd0);
      checkOutput("reset_wr_data", 64'(big_if.out_wr_data), 64'd0);
      checkOutput("reset_sat", 64'(big_if.sat_flag), 64'd0);
      checkOutput("reset_w_addr", 64'(big_if.w_rd_addr), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("idle_busy", 64'(big_if.busy), 64'd0);

      applyStimulus(0);
      run_engine(0, BIG_IN, BIG_OUT, BIG_CH, 1'b0);
      check_word("uniform_value", 0, 16'h7800);

      applyStimulus(2);
      run_engine(0, BIG_IN, BIG_OUT, BIG_CH, 1'b0);
      check_word("saturate_pos", 5, 16'h7FFF);

      applyStimulus(1);
      run_engine(0, BIG_IN, BIG_OUT, BIG_CH, 1'b0);
`ifdef FC_RELU_EN
      check_word("negative_bias", 10, 16'h0000);
`else
      check_word("negative_bias", 10, 16'h8980);
`endif

      applyStimulus(3);
      run_engine(0, BIG_IN, BIG_OUT, BIG_CH, 1'b1);
      applyStimulus(4);
      run_engine(0, BIG_IN, BIG_OUT, BIG_CH, 1'b0);

      // Abort a run at cycle 100 and confirm the outputs drop with no further writes.
      applyStimulus(0);
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_cyc_q.delete();
      @(negedge clk);
      big_if.start = 1'b1;
      start_cyc = cyc;
      @(negedge clk);
      big_if.start = 1'b0;
      repeat (99) @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("rst_wr_en", 64'(big_if.out_wr_en), 64'd0);
      checkOutput("rst_busy", 64'(big_if.busy), 64'd0);
      checkOutput("rst_done", 64'(big_if.done), 64'd0);
      n_before = wr_addr_q.size();
      checkOutput("writes_before_rst", 64'(n_before), 64'd3);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("writes_after_rst", 64'(wr_addr_q.size() - n_before), 64'd0);
      checkOutput("idle_after_rst", 64'(big_if.busy), 64'd0);
      run_engine(0, BIG_IN, BIG_OUT, BIG_CH, 1'b0);
      check_word("rerun_value", 83, 16'h7800);

      applyStimulus(0);
      run_engine(1, SML_IN, SML_OUT, SML_CH, 1'b0);
      check_word("tail_mask", 2, 16'h0A00);

      applyStimulus(5);
      run_engine(1, SML_IN, SML_OUT, SML_CH, 1'b0);
      check_word("round_up_half", 0, 16'h0001);
      check_word("round_neg_half", 1, 16'h0000);

      applyStimulus(4);
      run_engine(1, SML_IN, SML_OUT, SML_CH, 1'b0);
      applyStimulus(3);
      run_engine(1, SML_IN, SML_OUT, SML_CH, 1'b0);

      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
